// File: rtl/sigmoid_dense_latency_layer_packed_small.sv
// rtl/sigmoid_dense_latency_layer_packed_small.sv - pipelined fixed-point dense layer with packed multiplies

// Three signed multiplies sharing one operand, computed as a single wide product.
module macc_small #(
    parameter int WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [WIDTH-1:0]   a_i,
    input  logic signed [WIDTH-1:0]   w0_i,
    input  logic signed [WIDTH-1:0]   w1_i,
    input  logic signed [WIDTH-1:0]   w2_i,
    output logic signed [2*WIDTH-1:0] p0_o,
    output logic signed [2*WIDTH-1:0] p1_o,
    output logic signed [2*WIDTH-1:0] p2_o
);
    // Each field is wide enough to hold a full signed product without overlap.
    localparam int S  = 2 * WIDTH;
    localparam int PW = 3 * S;
    localparam int RW = PW + WIDTH;

    logic signed [PW-1:0] w0_x, w1_x, w2_x, w_pack;
    logic signed [RW-1:0] a_x, wp_x, prod_d, prod_q;
    logic signed [RW-1:0] sh1, r1, sh2, r2;

    // Pack the three weights as w0 + w1*2^S + w2*2^2S and form one signed product.
    always_comb begin
        w0_x   = w0_i;
        w1_x   = w1_i;
        w2_x   = w2_i;
        w_pack = w0_x + (w1_x <<< S) + (w2_x <<< (2 * S));
        a_x    = a_i;
        wp_x   = w_pack;
        prod_d = a_x * wp_x;
    end

    // Product register (first pipeline stage).
    always_ff @(posedge clk) begin
        if (reset) prod_q <= '0;
        else       prod_q <= prod_d;
    end

    // Unpack: a negative lower field borrows one from the field above, so add its sign back.
    always_comb begin
        sh1  = prod_q >>> S;
        r1   = sh1 + {{(RW-1){1'b0}}, prod_q[S-1]};
        sh2  = r1 >>> S;
        r2   = sh2 + {{(RW-1){1'b0}}, r1[S-1]};
        p0_o = prod_q[S-1:0];
        p1_o = r1[S-1:0];
        p2_o = r2[S-1:0];
    end
endmodule

// out[j] = bias[j] + sum_i(in[i] * w[i][j]), latency 3 + ceil(log2(INPUT_SIZE)).
module sigmoid_dense_latency_layer_packed_small #(
    parameter int WIDTH       = 5,
    parameter int NFRAC       = 3,
    parameter int INPUT_SIZE  = 32,
    parameter int OUTPUT_SIZE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] input_data  [0:INPUT_SIZE-1],
    input  logic signed [WIDTH-1:0] weights     [0:INPUT_SIZE*OUTPUT_SIZE-1],
    input  logic signed [WIDTH-1:0] biases      [0:OUTPUT_SIZE-1],
    output logic signed [WIDTH-1:0] output_data [0:OUTPUT_SIZE-1]
);
    localparam int NLEV = $clog2(INPUT_SIZE);
    localparam int NGRP = (OUTPUT_SIZE + 2) / 3;
    localparam int PW   = 2 * WIDTH;

    // Truncated products per column/row, then tree levels; level 0 is the capture register.
    logic [WIDTH-1:0] prod_w [0:OUTPUT_SIZE-1][0:INPUT_SIZE-1];
    logic [WIDTH-1:0] tree_q [0:NLEV][0:OUTPUT_SIZE-1][0:INPUT_SIZE-1];

    for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_row
        for (genvar gg = 0; gg < NGRP; gg++) begin : g_grp
            logic signed [WIDTH-1:0] w_slot [0:2];
            logic signed [PW-1:0]    p_slot [0:2];

            for (genvar gs = 0; gs < 3; gs++) begin : g_slot
                if (gg * 3 + gs < OUTPUT_SIZE) begin : g_used
                    assign w_slot[gs] = weights[gi * OUTPUT_SIZE + gg * 3 + gs];
                    // Keep bits [WIDTH+NFRAC-1:NFRAC]: floor toward -inf, wrap on overflow.
                    assign prod_w[gg * 3 + gs][gi] = p_slot[gs][WIDTH+NFRAC-1:NFRAC];
                end else begin : g_pad
                    assign w_slot[gs] = '0;
                end
            end

            macc_small #(.WIDTH(WIDTH)) u_macc (
                .clk   (clk),
                .reset (reset),
                .a_i   (input_data[gi]),
                .w0_i  (w_slot[0]),
                .w1_i  (w_slot[1]),
                .w2_i  (w_slot[2]),
                .p0_o  (p_slot[0]),
                .p1_o  (p_slot[1]),
                .p2_o  (p_slot[2])
            );
        end
    end

    // Product capture plus one register per adder-tree level; odd leftovers pass through.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l <= NLEV; l++)
                for (int j = 0; j < OUTPUT_SIZE; j++)
                    for (int k = 0; k < INPUT_SIZE; k++)
                        tree_q[l][j][k] <= '0;
        end else begin
            for (int j = 0; j < OUTPUT_SIZE; j++)
                for (int i = 0; i < INPUT_SIZE; i++)
                    tree_q[0][j][i] <= prod_w[j][i];
            for (int l = 1; l <= NLEV; l++) begin
                for (int j = 0; j < OUTPUT_SIZE; j++) begin
                    for (int k = 0; k < INPUT_SIZE; k++)
                        tree_q[l][j][k] <= '0;
                    for (int k = 0; k < INPUT_SIZE / 2; k++)
                        if (2 * k + 1 < ((INPUT_SIZE - 1) >> (l - 1)) + 1)
                            tree_q[l][j][k] <= tree_q[l-1][j][2*k] + tree_q[l-1][j][2*k+1];
                    for (int k = 0; k < (INPUT_SIZE + 1) / 2; k++)
                        if (2 * k + 1 == ((INPUT_SIZE - 1) >> (l - 1)) + 1)
                            tree_q[l][j][k] <= tree_q[l-1][j][2*k];
                end
            end
        end
    end

    // Bias add into the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < OUTPUT_SIZE; j++) output_data[j] <= '0;
        end else begin
            for (int j = 0; j < OUTPUT_SIZE; j++)
                output_data[j] <= tree_q[NLEV][j][0] + biases[j];
        end
    end
endmodule

// File: tb/tb_sigmoid_dense_latency_layer_packed_small.sv
// tb/tb_sigmoid_dense_latency_layer_packed_small.sv - randomized bench with behavioural dense-layer model
module tb_sigmoid_dense_latency_layer_packed_small;
    localparam int W    = 4;
    localparam int F    = 2;
    localparam int NI   = 7;
    localparam int NO   = 5;
    localparam int L    = 6;
    localparam int MAXC = 4000;

    logic clk = 1'b0;
    logic reset;
    logic signed [W-1:0] in_d  [0:NI-1];
    logic signed [W-1:0] w_d   [0:NI*NO-1];
    logic signed [W-1:0] b_d   [0:NO-1];
    logic signed [W-1:0] out_d [0:NO-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rst = 0;
    int last_cfg = 0;
    int hist [0:MAXC-1][0:NI-1];

    always #5 clk = ~clk;

    sigmoid_dense_latency_layer_packed_small #(
        .WIDTH(W), .NFRAC(F), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO)
    ) dut (
        .clk(clk), .reset(reset), .input_data(in_d), .weights(w_d),
        .biases(b_d), .output_data(out_d)
    );

    function automatic int wrap(int x);
        int v;
        v = x & ((1 << W) - 1);
        if (v >= (1 << (W - 1))) v -= (1 << W);
        return v;
    endfunction

    // Real-valued rule: sum of floor(in*w / 2^F) plus bias, all modulo 2^W.
    function automatic int model_out(int j, int v [NI]);
        int acc;
        acc = 0;
        for (int i = 0; i < NI; i++) acc += (v[i] * int'(w_d[i*NO+j])) >>> F;
        acc += int'(b_d[j]);
        return wrap(acc);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_lit(string name, int e0, int e1, int e2, int e3, int e4);
        int e [NO];
        e = '{e0, e1, e2, e3, e4};
        for (int j = 0; j < NO; j++) chk($sformatf("%s[%0d]", name, j), int'(out_d[j]), e[j]);
    endtask

    // Advance one clock, record what was sampled, and compare against the model when meaningful.
    task automatic step();
        int v [NI];
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) hist[cyc][i] = int'(in_d[i]);
        if (reset) last_rst = cyc;
        #1;
        if (reset) begin
            for (int j = 0; j < NO; j++) chk("reset_zero", int'(out_d[j]), 0);
        end else if (cyc - L + 1 >= last_cfg) begin
            for (int i = 0; i < NI; i++)
                v[i] = (cyc - last_rst < L) ? 0 : hist[cyc-L+1][i];
            for (int j = 0; j < NO; j++)
                chk($sformatf("model[%0d]", j), int'(out_d[j]), model_out(j, v));
        end
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg_mark();
        last_cfg = cyc + 1;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < NI; i++) in_d[i] = W'($urandom_range(0, 15));
    endtask

    task automatic rand_cfg();
        for (int k = 0; k < NI * NO; k++) w_d[k] = W'($urandom_range(0, 15));
        for (int j = 0; j < NO; j++) b_d[j] = W'($urandom_range(0, 15));
        cfg_mark();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NI; i++) in_d[i] = '0;
        for (int k = 0; k < NI * NO; k++) w_d[k] = '0;
        for (int j = 0; j < NO; j++) b_d[j] = '0;
        cfg_mark();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        rand_inputs();
        rand_cfg();

        // Reset held with random inputs, then quiet zero inputs.
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            step();
        end
        reset = 1'b0;
        for (int j = 0; j < NO; j++) b_d[j] = '0;
        for (int i = 0; i < NI; i++) in_d[i] = '0;
        cfg_mark();
        steps(L + 2);
        chk_lit("post_reset", 0, 0, 0, 0, 0);

        // Single impulse: measure latency and values.
        clear_all();
        for (int j = 0; j < NO; j++) w_d[j] = W'(j + 1);
        steps(L + 1);
        in_d[0] = 4'sd4;
        step();
        in_d[0] = '0;
        n = 1;
        while (n < 20 && out_d[0] != 4'sd1) begin
            step();
            n++;
        end
        chk("latency", n, L);
        chk_lit("row0_identity", 1, 2, 3, 4, 5);

        // Truncation toward -inf.
        clear_all();
        for (int j = 0; j < NO; j++) w_d[j] = 4'sd1;
        in_d[0] = -4'sd1;
        steps(L + 1);
        chk_lit("floor_neg", -1, -1, -1, -1, -1);
        in_d[0] = 4'sd1;
        steps(L);
        chk_lit("floor_pos", 0, 0, 0, 0, 0);

        // Wrap of the accumulated sum.
        for (int k = 0; k < NI * NO; k++) w_d[k] = 4'sd4;
        for (int i = 0; i < NI; i++) in_d[i] = 4'sd4;
        cfg_mark();
        steps(L + 1);
        chk_lit("wrap_sum", -4, -4, -4, -4, -4);

        // Bias only, then negative operands through the packed multiply.
        clear_all();
        b_d = '{4'sd3, -4'sd2, 4'sd1, -4'sd8, 4'sd7};
        steps(L + 1);
        chk_lit("bias_only", 3, -2, 1, -8, 7);
        clear_all();
        w_d[0] = -4'sd1; w_d[1] = 4'sd2; w_d[2] = -4'sd3; w_d[3] = 4'sd4; w_d[4] = -4'sd5;
        in_d[0] = -4'sd4;
        steps(L + 1);
        chk_lit("neg_pack", 1, -2, 3, -4, 5);

        // Random streaming, with a reset in the middle of each burst.
        for (int r = 0; r < 4; r++) begin
            rand_cfg();
            rand_inputs();
            steps(L);
            for (int k = 0; k < 120; k++) begin
                rand_inputs();
                reset = (k == 60 || k == 61);
                step();
            end
            reset = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
